// File: rtl/rv32i_core_pkg.sv
// rv32i_core_pkg: shared opcodes, funct3 codes, CSR addresses and ALU operations
package rv32i_core_pkg;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM = 7'h13, OP_OP = 7'h33, OP_SYSTEM = 7'h73;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;
  localparam logic [11:0] CSR_MTVEC = 12'h305, CSR_MEPC = 12'h341, CSR_MCAUSE = 12'h342, CSR_MHARTID = 12'hF14;
  localparam logic [31:0] INSN_ECALL = 32'h0000_0073, INSN_MRET = 32'h3020_0073;
  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND} alu_op_e;
  function automatic alu_op_e alu_dec(logic [2:0] f3, logic alt);
    return f3 == 3'd0 ? (alt ? ALU_SUB : ALU_ADD) : f3 == 3'd1 ? ALU_SLL : f3 == 3'd2 ? ALU_SLT :
           f3 == 3'd3 ? ALU_SLTU : f3 == 3'd4 ? ALU_XOR : f3 == 3'd5 ? (alt ? ALU_SRA : ALU_SRL) :
           f3 == 3'd6 ? ALU_OR : ALU_AND;
  endfunction
  function automatic logic [31:0] alu(alu_op_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'h0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'h0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction
endpackage

// File: rtl/rv32i_core_if.sv
// rv32i_core_if: per-cycle retirement trace driven by the core
interface rv32i_core_if;
  logic [31:0] pc, instr, rd_data, daddr;
  logic        rd_we;
  logic [4:0]  rd;
  logic [3:0]  be;
  modport master (output pc, instr, rd_data, daddr, rd_we, rd, be);
  modport slave  (input  pc, instr, rd_data, daddr, rd_we, rd, be);
endinterface

// File: rtl/rv32i_memory.sv
// rv32i_memory: unified word memory, combinational reads, byte-enabled synchronous write
module rv32i_memory #(
  parameter int MEM_WORDS = 65536,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] iaddr_i,
  output logic [31:0]   irdata_o,
  input  logic [AW-1:0] daddr_i,
  output logic [31:0]   drdata_o,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i
);
  logic [31:0] m [0:MEM_WORDS-1];
  assign irdata_o = m[iaddr_i];
  assign drdata_o = m[daddr_i];
  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++) if (be_i[i]) m[daddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
endmodule

// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I core with embedded unified memory and CSR file
module rv32i_core import rv32i_core_pkg::*; #(
  parameter int          MEM_WORDS = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  rv32i_core_if.master trace
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [31:0] pc_q, pc_d;
  logic [31:0] rs  [0:31];
  logic [31:0] csr [0:4095];
  logic [31:0] instr, drdata, wdata, daddr, a, b, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_y, ld, csr_old, csr_src, csr_new, wb;
  logic [15:0] hsel;
  logic [7:0]  bsel;
  logic [6:0]  opc;
  logic [4:0]  rd, r1, r2;
  logic [2:0]  f3;
  logic [11:0] csr_a;
  logic [3:0]  be;
  logic        taken, rd_we, csr_we, is_csr, ecall, mret;
  rv32i_memory #(.MEM_WORDS(MEM_WORDS)) memory (
    .clk      (clk),
    .iaddr_i  (pc_q[AW+1:2]),
    .irdata_o (instr),
    .daddr_i  (daddr[AW+1:2]),
    .drdata_o (drdata),
    .wdata_i  (wdata),
    .be_i     (rst ? 4'h0 : be)
  );
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign r1    = instr[19:15];
  assign r2    = instr[24:20];
  assign csr_a = instr[31:20];
  assign a     = rs[r1];
  assign b     = rs[r2];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign alu_y = alu(alu_dec(f3, instr[30] && (opc == OP_OP || f3 == 3'd5)), a, opc == OP_OP ? b : imm_i);
  assign taken = f3 == F3_BEQ ? a == b : f3 == F3_BNE ? a != b :
                 f3 == F3_BLT ? $signed(a) < $signed(b) : f3 == F3_BGE ? $signed(a) >= $signed(b) :
                 f3 == F3_BLTU ? a < b : f3 == F3_BGEU ? a >= b : 1'b0;
  assign daddr = a + (opc == OP_STORE ? imm_s : imm_i);
  assign bsel  = 8'(drdata >> {daddr[1:0], 3'b000});
  assign hsel  = 16'(drdata >> {daddr[1], 4'b0000});
  assign ld    = f3 == F3_B ? {{24{bsel[7]}}, bsel} : f3 == F3_H ? {{16{hsel[15]}}, hsel} :
                 f3 == F3_BU ? {24'h0, bsel} : f3 == F3_HU ? {16'h0, hsel} : drdata;
  assign be    = opc != OP_STORE ? 4'h0 : f3 == F3_B ? 4'b0001 << daddr[1:0] :
                 f3 == F3_H ? (daddr[1] ? 4'b1100 : 4'b0011) : f3 == F3_W ? 4'hF : 4'h0;
  assign wdata = f3 == F3_B ? {4{b[7:0]}} : f3 == F3_H ? {2{b[15:0]}} : b;
  assign is_csr  = opc == OP_SYSTEM && f3[1:0] != 2'b00;
  assign ecall   = instr == INSN_ECALL;
  assign mret    = instr == INSN_MRET;
  assign csr_old = csr_a == CSR_MHARTID ? 32'h0 : csr[csr_a];
  assign csr_src = f3[2] ? {27'h0, r1} : a;
  assign csr_new = f3[1:0] == 2'b01 ? csr_src : f3[1:0] == 2'b10 ? csr_old | csr_src : csr_old & ~csr_src;
  assign csr_we  = is_csr && (f3[1:0] == 2'b01 || r1 != 5'd0) && csr_a != CSR_MHARTID;
  assign wb    = opc == OP_LUI ? imm_u : opc == OP_AUIPC ? pc_q + imm_u :
                 opc == OP_JAL || opc == OP_JALR ? pc_q + 32'd4 : opc == OP_LOAD ? ld : is_csr ? csr_old : alu_y;
  assign rd_we = rd != 5'd0 && (is_csr || opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP});
  assign pc_d  = opc == OP_JAL ? pc_q + imm_j : opc == OP_JALR ? (a + imm_i) & ~32'h1 :
                 opc == OP_BRANCH && taken ? pc_q + imm_b : ecall ? {csr[CSR_MTVEC][31:2], 2'b00} :
                 mret ? csr[CSR_MEPC] : pc_q + 32'd4;
  assign trace.pc      = pc_q;
  assign trace.instr   = instr;
  assign trace.rd_data = wb;
  assign trace.daddr   = daddr;
  assign trace.rd_we   = rd_we;
  assign trace.rd      = rd;
  assign trace.be      = be;
  // Commit pc, GPR and CSR state each cycle; ECALL also records mepc and mcause.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) rs[i] <= '0;
      for (int i = 0; i < 4096; i++) csr[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (rd_we) rs[rd] <= wb;
      if (csr_we) csr[csr_a] <= csr_new;
      if (ecall) begin
        csr[CSR_MEPC]   <= pc_q;
        csr[CSR_MCAUSE] <= 32'd11;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed architectural checks plus a random program checked against an instruction-level model
module tb_rv32i_core;
  logic clk = 1'b0, rst = 1'b1;
  int n_cmp = 0, n_err = 0;
  logic [31:0] mr [0:31];
  logic [31:0] mm [0:511];
  logic [31:0] mpc;
  rv32i_core_if trace();
  rv32i_core dut (.clk(clk), .rst(rst), .trace(trace));
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd, logic [2:0] f3, logic [4:0] r1, logic [31:0] im);
    return {im[11:0], r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1, logic [2:0] f3, logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [2:0] f3, logic [4:0] r2, logic [4:0] r1, logic [31:0] im);
    return {im[11:5], r2, r1, f3, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [2:0] f3, logic [4:0] r1, logic [4:0] r2, logic [31:0] im);
    return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] rd, logic [31:0] im);
    return {im[19:0], rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [4:0] rd, logic [31:0] im);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(int addr, logic [31:0] w);
    dut.memory.m[addr / 4] = w;
  endtask
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic model_step(output logic [4:0] rd_o, output int st_idx);
    logic [31:0] ins, a, b, ii, si, y, res, ea, w;
    logic [4:0] sh;
    logic [2:0] f3;
    logic wr;
    ins = mm[mpc[10:2]];
    f3 = ins[14:12];
    a = mr[ins[19:15]];
    b = mr[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    wr = 1'b1;
    res = 32'h0;
    st_idx = -1;
    case (ins[6:0])
      7'h37: res = {ins[31:12], 12'h0};
      7'h17: res = mpc + {ins[31:12], 12'h0};
      7'h13, 7'h33: begin
        y = ins[5] ? b : ii;
        sh = y[4:0];
        case (f3)
          3'd0: res = (ins[5] && ins[30]) ? a - y : a + y;
          3'd1: res = a << sh;
          3'd2: res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
          3'd3: res = (a < y) ? 32'd1 : 32'd0;
          3'd4: res = a ^ y;
          3'd5: res = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: res = a | y;
          default: res = a & y;
        endcase
      end
      7'h03: begin
        ea = a + ii;
        w = mm[ea[10:2]];
        case (f3)
          3'd0: begin w = w >> (8 * ea[1:0]); res = {{24{w[7]}}, w[7:0]}; end
          3'd1: begin w = w >> (16 * ea[1]); res = {{16{w[15]}}, w[15:0]}; end
          3'd4: begin w = w >> (8 * ea[1:0]); res = {24'h0, w[7:0]}; end
          3'd5: begin w = w >> (16 * ea[1]); res = {16'h0, w[15:0]}; end
          default: res = w;
        endcase
      end
      7'h23: begin
        wr = 1'b0;
        ea = a + si;
        st_idx = int'(ea[10:2]);
        case (f3)
          3'd0: mm[st_idx][8*ea[1:0] +: 8] = b[7:0];
          3'd1: mm[st_idx][16*ea[1] +: 16] = b[15:0];
          default: mm[st_idx] = b;
        endcase
      end
      default: wr = 1'b0;
    endcase
    if (wr && ins[11:7] != 5'd0) mr[ins[11:7]] = res;
    rd_o = ins[11:7];
    mpc = mpc + 32'd4;
  endtask

  initial begin
    logic [4:0] rd, r1, r2;
    logic [2:0] f;
    logic [31:0] im;
    logic [6:0] f7;
    int idx;
    logic [2:0] ldf [0:4];
    ldf[0] = 3'd0; ldf[1] = 3'd1; ldf[2] = 3'd2; ldf[3] = 3'd4; ldf[4] = 3'd5;

    put(0, enc_i(7'h13, 1, 0, 0, 5));
    tick();
    check("reset_pc", dut.pc_q, 32'h0);
    check("reset_x1", dut.rs[1], 32'h0);
    rst = 1'b0;
    #1;
    check("trace_rd_data", trace.rd_data, 32'd5);
    check("trace_rd_we", {31'h0, trace.rd_we}, 32'd1);
    tick();
    check("addi_x1", dut.rs[1], 32'd5);
    check("addi_pc", dut.pc_q, 32'h4);

    put(0, enc_u(7'h37, 1, 32'hFF00F));
    put(4, enc_i(7'h13, 2, 6, 1, 32'h0F0));
    put(8, enc_i(7'h13, 0, 6, 1, 32'h0F0));
    restart();
    repeat (3) tick();
    check("lui_x1", dut.rs[1], 32'hFF00F000);
    check("ori_x2", dut.rs[2], 32'hFF00F0F0);
    check("ori_x0", dut.rs[0], 32'h0);

    put(32'h104, 32'h0);
    put(32'h00, enc_u(7'h37, 1, 32'h12345));
    put(32'h04, enc_i(7'h13, 1, 0, 1, 32'h678));
    put(32'h08, enc_s(2, 1, 0, 32'h100));
    put(32'h0C, enc_i(7'h03, 2, 0, 0, 32'h103));
    put(32'h10, enc_i(7'h03, 3, 4, 0, 32'h103));
    put(32'h14, enc_i(7'h03, 4, 1, 0, 32'h102));
    put(32'h18, enc_i(7'h03, 5, 2, 0, 32'h100));
    put(32'h1C, enc_s(0, 1, 0, 32'h105));
    put(32'h20, enc_i(7'h03, 6, 4, 0, 32'h105));
    restart();
    repeat (9) tick();
    check("sw_mem", dut.memory.m[32'h40], 32'h12345678);
    check("lb_x2", dut.rs[2], 32'h12);
    check("lbu_x3", dut.rs[3], 32'h12);
    check("lh_x4", dut.rs[4], 32'h1234);
    check("lw_x5", dut.rs[5], 32'h12345678);
    check("sb_mem", dut.memory.m[32'h41], 32'h00007800);
    check("lbu_x6", dut.rs[6], 32'h78);

    put(32'h00, enc_i(7'h13, 1, 0, 0, 1));
    put(32'h04, enc_b(1, 1, 0, 8));
    put(32'h08, enc_i(7'h13, 2, 0, 0, 9));
    put(32'h0C, enc_i(7'h13, 3, 0, 0, 7));
    put(32'h10, enc_j(0, 32'h10));
    put(32'h20, enc_j(1, 8));
    put(32'h24, enc_i(7'h13, 4, 0, 0, 1));
    put(32'h28, enc_b(0, 1, 0, 8));
    put(32'h2C, enc_i(7'h67, 5, 0, 1, 1));
    restart();
    repeat (2) tick();
    check("bne_pc", dut.pc_q, 32'h0C);
    tick();
    check("bne_x3", dut.rs[3], 32'd7);
    repeat (2) tick();
    check("jal_x1", dut.rs[1], 32'h24);
    check("jal_pc", dut.pc_q, 32'h28);
    check("bne_skip_x2", dut.rs[2], 32'h0);
    tick();
    check("beq_nt_pc", dut.pc_q, 32'h2C);
    tick();
    check("jalr_x5", dut.rs[5], 32'h30);
    check("jalr_pc", dut.pc_q, 32'h24);

    put(32'h00, enc_i(7'h13, 1, 0, 0, 32'h80));
    put(32'h04, enc_i(7'h73, 0, 1, 1, 32'h305));
    put(32'h08, enc_j(0, 32'h38));
    put(32'h40, 32'h0000_0073);
    put(32'h80, enc_i(7'h73, 2, 2, 0, 32'h305));
    put(32'h84, enc_i(7'h73, 3, 5, 5, 32'hF14));
    put(32'h88, enc_i(7'h73, 0, 3, 1, 32'h305));
    put(32'h8C, 32'h3020_0073);
    restart();
    repeat (2) tick();
    check("csrrw_mtvec", dut.csr[12'h305], 32'h80);
    tick();
    check("jump_pc", dut.pc_q, 32'h40);
    tick();
    check("ecall_pc", dut.pc_q, 32'h80);
    check("ecall_mepc", dut.csr[12'h341], 32'h40);
    check("ecall_mcause", dut.csr[12'h342], 32'd11);
    tick();
    check("csrrs_x2", dut.rs[2], 32'h80);
    check("csrrs_nowrite", dut.csr[12'h305], 32'h80);
    tick();
    check("mhartid_x3", dut.rs[3], 32'h0);
    check("mhartid_nowrite", dut.csr[12'hF14], 32'h0);
    tick();
    check("csrrc_mtvec", dut.csr[12'h305], 32'h0);
    tick();
    check("mret_pc", dut.pc_q, 32'h40);
    rst = 1'b1;
    tick();
    check("midreset_pc", dut.pc_q, 32'h0);
    check("midreset_mcause", dut.csr[12'h342], 32'h0);

    for (int k = 0; k < 512; k++) mm[k] = (k >= 384) ? $urandom : 32'h0;
    for (int k = 0; k < 200; k++) begin
      rd = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      f = 3'($urandom_range(0, 7));
      im = $urandom;
      case ($urandom_range(0, 7))
        0, 1: begin
          if (f == 3'd1) im = im & 32'h01F;
          if (f == 3'd5) im = im & 32'h41F;
          mm[k] = enc_i(7'h13, rd, f, r1, im);
        end
        2, 3: begin
          f7 = ((f == 3'd0 || f == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          mm[k] = enc_r(f7, r2, r1, f, rd);
        end
        4: mm[k] = enc_u($urandom_range(0, 1) == 1 ? 7'h37 : 7'h17, rd, im);
        5: mm[k] = enc_s(3'($urandom_range(0, 2)), r2, 0, $urandom_range(32'h600, 32'h7FF));
        default: mm[k] = enc_i(7'h03, rd, ldf[$urandom_range(0, 4)], 0, $urandom_range(32'h600, 32'h7FF));
      endcase
    end
    for (int k = 0; k < 512; k++) dut.memory.m[k] = mm[k];
    for (int k = 0; k < 32; k++) mr[k] = 32'h0;
    mpc = 32'h0;
    restart();
    for (int k = 0; k < 200; k++) begin
      model_step(rd, idx);
      tick();
      check($sformatf("rnd%0d_pc", k), dut.pc_q, mpc);
      check($sformatf("rnd%0d_x%0d", k, rd), dut.rs[rd], mr[rd]);
      if (idx >= 0) check($sformatf("rnd%0d_mem%0d", k, idx), dut.memory.m[idx], mm[idx]);
    end
    for (int k = 0; k < 8; k++) check($sformatf("final_x%0d", k), dut.rs[k], mr[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
